// File: rtl/uart_arb_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding, client-count limits
// and the byte type.
package uart_arb_pkg;

  localparam int unsigned ClientsMin = 2;
  localparam int unsigned ClientsMax = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StTxReq  = 2'd1,
    StTxRel  = 2'd2,
    StCliAck = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester at or above ptr_i, wrapping
// modulo N.
module rr_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int unsigned cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = IdxW'(cand);
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_CLIENTS four-phase req/ack byte
// producers. Define UART_ARB_TIMEOUT_EN to add the transmitter watchdog and sticky err.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_CLIENTS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_CLIENTS-1:0]   cli_req,
  input  logic [8*N_CLIENTS-1:0] cli_data,
  output logic [N_CLIENTS-1:0]   cli_ack,
  output logic [N_CLIENTS-1:0]   grant,
  output logic                   tx_req,
  output logic [7:0]             tx_data,
  input  logic                   tx_ack,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned IdxW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [N_CLIENTS-1:0] grant_q, grant_d;
  logic [N_CLIENTS-1:0] cli_ack_q, cli_ack_d;
  byte_t                tx_data_q, tx_data_d;
  logic                 tx_req_q, tx_req_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  byte_t                cli_bytes [N_CLIENTS];
  logic [N_CLIENTS-1:0] pick_gnt;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;
  logic                 timeout_hit;

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_bytes
    assign cli_bytes[g] = cli_data[8*g +: 8];
  end

  rr_picker #(
    .N    (N_CLIENTS),
    .IdxW (IdxW)
  ) u_rr_picker (
    .req_i (cli_req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            waiting;

  assign waiting = (state_q == StTxReq) || (state_q == StTxRel);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle && pick_any) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires in the cycle whose edge brings the count up to TIMEOUT_CYCLES.
  assign timeout_hit = waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    cli_ack_d = cli_ack_q;
    tx_data_d = tx_data_q;
    tx_req_d  = tx_req_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          tx_data_d = cli_bytes[pick_idx];
          grant_d   = pick_gnt;
          idx_d     = pick_idx;
          tx_req_d  = 1'b1;
          state_d   = StTxReq;
        end
      end
      StTxReq: begin
        if (tx_ack) begin
          tx_req_d = 1'b0;
          state_d  = StTxRel;
        end else if (timeout_hit) begin
          tx_req_d  = 1'b0;
          err_d     = 1'b1;
          cli_ack_d = grant_q;
          state_d   = StCliAck;
        end
      end
      StTxRel: begin
        if (!tx_ack || timeout_hit) begin
          err_d     = err_q | tx_ack;
          cli_ack_d = grant_q;
          state_d   = StCliAck;
        end
      end
      StCliAck: begin
        if (!cli_req[idx_q]) begin
          cli_ack_d = '0;
          grant_d   = '0;
          ptr_d     = (32'(idx_q) == N_CLIENTS - 1) ? '0 : idx_q + 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      cli_ack_q <= '0;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      cli_ack_q <= cli_ack_d;
      tx_data_q <= tx_data_d;
      tx_req_q  <= tx_req_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign cli_ack = cli_ack_q;
  assign grant   = grant_q;
  assign tx_req  = tx_req_q;
  assign tx_data = tx_data_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with four clients.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        clr;
  logic [3:0]  cli_req;
  logic [31:0] cli_data;
  logic [3:0]  cli_ack;
  logic [3:0]  grant;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_ack;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter #(
    .N_CLIENTS      (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .cli_req  (cli_req),
    .cli_data (cli_data),
    .cli_ack  (cli_ack),
    .grant    (grant),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_tx_req(input logic lvl, input string tag);
    for (int i = 0; i < 40 && tx_req !== lvl; i++) @(negedge clk);
    check_eq(tag, 32'(tx_req), 32'(lvl));
  endtask

  task automatic wait_cli_ack(input int client, input logic lvl, input string tag);
    for (int i = 0; i < 40 && cli_ack[client] !== lvl; i++) @(negedge clk);
    check_eq(tag, 32'(cli_ack[client]), 32'(lvl));
  endtask

  // One full transaction for the expected client; transmitter acks after ack_dly cycles.
  task automatic serve(input int client, input int ack_dly, input logic [7:0] exp_data);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << client;
    wait_tx_req(1'b1, "tx_req_rise");
    check_eq("grant", 32'(grant), 32'(exp_gnt));
    check_eq("tx_data", 32'(tx_data), 32'(exp_data));
    check_eq("busy_hi", 32'(busy), 32'd1);
    repeat (ack_dly) @(negedge clk);
    check_eq("tx_req_hold", 32'(tx_req), 32'd1);
    tx_ack = 1'b1;
    wait_tx_req(1'b0, "tx_req_fall");
    check_eq("grant_stable", 32'(grant), 32'(exp_gnt));
    check_eq("cli_ack_early", 32'(cli_ack), 32'd0);
    tx_ack = 1'b0;
    wait_cli_ack(client, 1'b1, "cli_ack_rise");
    check_eq("cli_ack_vec", 32'(cli_ack), 32'(exp_gnt));
    check_eq("tx_data_stable", 32'(tx_data), 32'(exp_data));
    cli_req[client] = 1'b0;
    wait_cli_ack(client, 1'b0, "cli_ack_fall");
    check_eq("grant_clear", 32'(grant), 32'd0);
    check_eq("busy_lo", 32'(busy), 32'd0);
  endtask

  initial begin
    clr      = 1'b1;
    cli_req  = '0;
    cli_data = '0;
    tx_ack   = 1'b0;
    #1;
    check_eq("rst_tx_req", 32'(tx_req), 32'd0);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_cli_ack", 32'(cli_ack), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check_eq("idle_no_req", 32'(busy), 32'd0);

    // Single client 2; ptr moves to 3, so {0,3} then resolves 3 before 0.
    cli_data = 32'h00A5_0000;
    cli_req  = 4'b0100;
    serve(2, 3, 8'hA5);
    cli_data = 32'h1312_1110;
    cli_req  = 4'b1001;
    serve(3, 0, 8'h13);
    serve(0, 0, 8'h10);

    // All four at once from reset: order 0,1,2,3; ptr back to 0.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cli_req = 4'b1111;
    serve(0, 0, 8'h10);
    serve(1, 1, 8'h11);
    serve(2, 0, 8'h12);
    serve(3, 2, 8'h13);
    cli_req = 4'b0101;
    serve(0, 0, 8'h10);
    serve(2, 0, 8'h12);

    // Contention: client 1 arrives during client 3's service (ptr=3).
    cli_req[3] = 1'b1;
    @(negedge clk);
    cli_req[1] = 1'b1;
    serve(3, 2, 8'h13);
    serve(1, 0, 8'h11);

    // Data change after grant: tx_data keeps the latched byte.
    cli_data[7:0] = 8'h55;
    cli_req[0]    = 1'b1;
    @(negedge clk);
    cli_data[7:0] = 8'hAA;
    serve(0, 2, 8'h55);

    // Reset in TX_REL; ptr was 1, so {0,2} must resolve to 0 afterwards.
    cli_data   = 32'h1312_1110;
    cli_req[2] = 1'b1;
    wait_tx_req(1'b1, "rst_mid_req");
    tx_ack = 1'b1;
    wait_tx_req(1'b0, "rst_mid_rel");
    #2 clr = 1'b1;
    #1;
    check_eq("rst_mid_tx_req", 32'(tx_req), 32'd0);
    check_eq("rst_mid_grant", 32'(grant), 32'd0);
    check_eq("rst_mid_cli_ack", 32'(cli_ack), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    cli_req = '0;
    tx_ack  = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    cli_req = 4'b0101;
    serve(0, 0, 8'h10);
    serve(2, 0, 8'h12);

`ifdef UART_ARB_TIMEOUT_EN
    // Watchdog: tx_ack never comes; 20 cycles in TX_REQ then forced ack.
    cli_req[1] = 1'b1;
    wait_tx_req(1'b1, "to_req");
    repeat (19) @(negedge clk);
    check_eq("to_hold", 32'(tx_req), 32'd1);
    check_eq("to_err_pre", 32'(err), 32'd0);
    @(negedge clk);
    check_eq("to_tx_req", 32'(tx_req), 32'd0);
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_cli_ack", 32'(cli_ack), 32'b0010);
    cli_req[1] = 1'b0;
    wait_cli_ack(1, 1'b0, "to_cli_ack_fall");
    repeat (3) @(negedge clk);
    check_eq("to_err_sticky", 32'(err), 32'd1);
    clr = 1'b1;
    #1;
    check_eq("to_err_clr", 32'(err), 32'd0);
    @(negedge clk);
    clr = 1'b0;
`endif

    @(negedge clk);
    check_eq("final_err", 32'(err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
